// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, control word, immediate formats and
// the immediate-extraction helpers used by decode_stage.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  localparam rv32i_opcode OPC_LOAD = op_load;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [3:0] {
    alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
    alu_xor, alu_srl, alu_sra, alu_or,  alu_and
  } alu_ops;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_sel_t;

  typedef struct packed {
    rv32i_opcode opcode;
    alu_ops      aluop;
    logic [2:0]  funct3;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
    logic        alu_use_imm;
    logic        alu_use_pc;
    logic        is_branch;
    logic        is_jump;
  } rv32i_control_word;

  function automatic imm_sel_t imm_sel(input logic [6:0] opcode);
    case (opcode)
      op_imm, op_load, op_jalr: return IMM_I;
      op_store:                 return IMM_S;
      op_br:                    return IMM_B;
      op_lui, op_auipc:         return IMM_U;
      op_jal:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_value(input logic [31:0] instr, input imm_sel_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cmp.sv
// Branch comparator: BEQ/BNE/BLT/BGE/BLTU/BGEU on two operands.
module cmp
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_br_en
);

  always_comb begin
    o_br_en = 1'b0;
    case (i_funct3)
      beq:     o_br_en = (i_a == i_b);
      bne:     o_br_en = (i_a != i_b);
      blt:     o_br_en = ($signed(i_a) <  $signed(i_b));
      bge:     o_br_en = ($signed(i_a) >= $signed(i_b));
      bltu:    o_br_en = (i_a <  i_b);
      bgeu:    o_br_en = (i_a >= i_b);
      default: o_br_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_rom.sv
// Opcode/funct decode into the RV32I control word.
module control_rom
  import rv32i_types::*;
(
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic              i_funct7_5,
  output rv32i_control_word o_ctrl
);

  function automatic alu_ops f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? alu_sub : alu_add;
      3'b001:  return alu_sll;
      3'b010:  return alu_slt;
      3'b011:  return alu_sltu;
      3'b100:  return alu_xor;
      3'b101:  return alt ? alu_sra : alu_srl;
      3'b110:  return alu_or;
      default: return alu_and;
    endcase
  endfunction

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.opcode = rv32i_opcode'(i_opcode);
    o_ctrl.funct3 = i_funct3;
    o_ctrl.aluop  = alu_add;
    case (i_opcode)
      op_lui: begin
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
      end
      op_auipc: begin
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
        o_ctrl.alu_use_pc   = 1'b1;
      end
      op_jal: begin
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.is_jump      = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
        o_ctrl.alu_use_pc   = 1'b1;
      end
      op_jalr: begin
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.is_jump      = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
      end
      op_br: begin
        o_ctrl.is_branch    = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
        o_ctrl.alu_use_pc   = 1'b1;
      end
      op_load: begin
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
      end
      op_store: begin
        o_ctrl.mem_write    = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
      end
      op_imm: begin
        // Only the shift-right-immediate uses funct7[5] (SRAI).
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.alu_use_imm  = 1'b1;
        o_ctrl.aluop        = f3_alu(i_funct3, i_funct7_5 && (i_funct3 == 3'b101));
      end
      op_reg: begin
        o_ctrl.load_regfile = 1'b1;
        o_ctrl.aluop        = f3_alu(i_funct3, i_funct7_5);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_regfile.sv
// Architectural register file with write-through reads; x0 and indices
// at or above NUM_REGS read as zero and ignore writes.
module decode_regfile
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [4:0]       i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  output logic [WIDTH-1:0] o_rs1_data,
  output logic [WIDTH-1:0] o_rs2_data
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             w_wr_ok;

  function automatic logic in_range(input logic [4:0] idx);
    return (32'(idx) < NUM_REGS) && (idx != '0);
  endfunction

  assign w_wr_ok = i_we && in_range(i_wr_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_wr_idx[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rs1_data = !in_range(i_rs1)                  ? '0        :
                      (w_wr_ok && i_wr_idx == i_rs1)    ? i_wr_data :
                                                          r_regs[i_rs1[AW-1:0]];
  assign o_rs2_data = !in_range(i_rs2)                  ? '0        :
                      (w_wr_ok && i_wr_idx == i_rs2)    ? i_wr_data :
                                                          r_regs[i_rs2[AW-1:0]];

endmodule

// File: rtl/decode_stage.sv
// Decode stage with integrated ID/EX register, load-use bubbles and flush.
// Optional macro DECODE_HAZARD_CNT_EN enables the saturating bubble counter.
module decode_stage
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [31:0]       if_instr_i,
  input  logic [WIDTH-1:0]  if_pc_i,
  output logic              id_ready_o,
  input  logic              ex_ready_i,
  output logic              ex_valid_o,
  output rv32i_control_word ex_ctrl_word_o,
  output logic [31:0]       ex_instr_o,
  output logic [WIDTH-1:0]  ex_pc_o,
  output logic [WIDTH-1:0]  ex_rs1_data_o,
  output logic [WIDTH-1:0]  ex_rs2_data_o,
  output logic [WIDTH-1:0]  ex_imm_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_br_en_o,
  input  logic              flush_i,
  input  logic              wb_load_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [WIDTH-1:0]  wb_data_i,
  output logic [31:0]       hazard_cnt_o
);

  logic [6:0]        w_opcode;
  logic [4:0]        w_rs1, w_rs2, w_rd;
  logic [2:0]        w_funct3;
  logic              w_rs1_used, w_rs2_used;
  logic [WIDTH-1:0]  w_rs1_data, w_rs2_data, w_imm;
  logic              w_cmp, w_br_en;
  rv32i_control_word w_ctrl;
  logic              w_adv, w_haz, w_bubble, w_wb_hit;

  logic              r_valid;
  rv32i_control_word r_ctrl;
  logic [31:0]       r_instr;
  logic [WIDTH-1:0]  r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]        r_rs1, r_rs2, r_rd;
  logic              r_br_en;

  assign w_opcode = if_instr_i[6:0];
  assign w_rd     = if_instr_i[11:7];
  assign w_funct3 = if_instr_i[14:12];
  assign w_rs1    = if_instr_i[19:15];
  assign w_rs2    = if_instr_i[24:20];

  assign w_rs1_used = !(w_opcode == op_lui || w_opcode == op_auipc || w_opcode == op_jal);
  assign w_rs2_used = (w_opcode == op_reg || w_opcode == op_store || w_opcode == op_br);

  control_rom u_control_rom (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7_5 (if_instr_i[30]),
    .o_ctrl     (w_ctrl)
  );

  decode_regfile #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (wb_load_i),
    .i_wr_idx   (wb_rd_i),
    .i_wr_data  (wb_data_i),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .i_funct3 (w_funct3),
    .i_a      (w_rs1_data),
    .i_b      (w_rs2_data),
    .o_br_en  (w_cmp)
  );

  assign w_br_en = (w_opcode == op_br) && w_cmp;
  assign w_imm   = WIDTH'($signed(imm_value(if_instr_i, imm_sel(w_opcode))));

  assign w_adv    = !r_valid || ex_ready_i;
  assign w_haz    = r_valid && (r_instr[6:0] == OPC_LOAD) && (r_rd != '0) &&
                    ((w_rs1_used && w_rs1 == r_rd) || (w_rs2_used && w_rs2 == r_rd));
  assign w_bubble = w_adv && w_haz && !flush_i;
  assign w_wb_hit = wb_load_i && (wb_rd_i != '0);

  assign id_ready_o = flush_i || (w_adv && !w_haz);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_br_en    <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (!w_adv) begin
      // Held operands track writebacks so EX never consumes a stale value.
      if (w_wb_hit && wb_rd_i == r_rs1) r_rs1_data <= wb_data_i;
      if (w_wb_hit && wb_rd_i == r_rs2) r_rs2_data <= wb_data_i;
    end else if (w_haz) begin
      r_valid <= 1'b0;
    end else begin
      r_valid    <= if_valid_i;
      r_ctrl     <= w_ctrl;
      r_instr    <= if_instr_i;
      r_pc       <= if_pc_i;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_br_en    <= w_br_en;
    end
  end

  assign ex_valid_o     = r_valid;
  assign ex_ctrl_word_o = r_ctrl;
  assign ex_instr_o     = r_instr;
  assign ex_pc_o        = r_pc;
  assign ex_rs1_data_o  = r_rs1_data;
  assign ex_rs2_data_o  = r_rs2_data;
  assign ex_imm_o       = r_imm;
  assign ex_rs1_o       = r_rs1;
  assign ex_rs2_o       = r_rs2;
  assign ex_rd_o        = r_rd;
  assign ex_br_en_o     = r_br_en;

`ifdef DECODE_HAZARD_CNT_EN
  logic [31:0] r_hazard_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hazard_cnt <= '0;
    end else if (w_bubble && r_hazard_cnt != '1) begin
      r_hazard_cnt <= r_hazard_cnt + 32'd1;
    end
  end

  assign hazard_cnt_o = r_hazard_cnt;
`else
  logic w_bubble_unused;
  assign w_bubble_unused = w_bubble;
  assign hazard_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then random
// traffic, all compared against a behavioural pipeline/regfile model.
module tb_decode_stage;

  localparam int unsigned W = 32;
`ifdef DECODE_HAZARD_CNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid_i, ex_ready_i, flush_i, wb_load_i;
  logic [31:0] if_instr_i, if_pc_i, wb_data_i;
  logic [4:0]  wb_rd_i;

  logic        id_ready_o, ex_valid_o, ex_br_en_o;
  rv32i_types::rv32i_control_word ex_ctrl_word_o;
  logic [31:0] ex_instr_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, hazard_cnt_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;

  logic        d16_ready, d16_valid, d16_br_en;
  rv32i_types::rv32i_control_word d16_ctrl;
  logic [31:0] d16_instr, d16_pc, d16_rs1_data, d16_rs2_data, d16_imm, d16_cnt;
  logic [4:0]  d16_rs1, d16_rs2, d16_rd;

  decode_stage #(.WIDTH(W), .NUM_REGS(32)) u_dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_ready_o(id_ready_o), .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
    .ex_ctrl_word_o(ex_ctrl_word_o), .ex_instr_o(ex_instr_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_br_en_o(ex_br_en_o),
    .flush_i(flush_i), .wb_load_i(wb_load_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .hazard_cnt_o(hazard_cnt_o)
  );

  decode_stage #(.WIDTH(W), .NUM_REGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_ready_o(d16_ready), .ex_ready_i(ex_ready_i), .ex_valid_o(d16_valid),
    .ex_ctrl_word_o(d16_ctrl), .ex_instr_o(d16_instr), .ex_pc_o(d16_pc),
    .ex_rs1_data_o(d16_rs1_data), .ex_rs2_data_o(d16_rs2_data), .ex_imm_o(d16_imm),
    .ex_rs1_o(d16_rs1), .ex_rs2_o(d16_rs2), .ex_rd_o(d16_rd), .ex_br_en_o(d16_br_en),
    .flush_i(flush_i), .wb_load_i(wb_load_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .hazard_cnt_o(d16_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: architectural registers plus the contents of the EX slot.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_rs1d, m_rs2d, m_imm, m_cnt;
  logic        m_br;
  logic [31:0] pc_ctr;

  function automatic logic [31:0] f_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_load_i && wb_rd_i == idx) return wb_data_i;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return {{20{i[31]}}, i[31:20]};
      7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
      7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic f_br(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    if (i[6:0] != 7'b1100011) return 1'b0;
    case (i[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_haz();
    logic [6:0] op;
    logic u1, u2;
    op = if_instr_i[6:0];
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    return m_valid && m_instr[6:0] == 7'b0000011 && m_instr[11:7] != 0 &&
           ((u1 && if_instr_i[19:15] == m_instr[11:7]) || (u2 && if_instr_i[24:20] == m_instr[11:7]));
  endfunction

  task automatic model_edge();
    logic adv, haz;
    adv = !m_valid || ex_ready_i;
    haz = f_haz();
    if (rst) begin
      m_valid = 0; m_instr = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_br = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      return;
    end
    if (flush_i) m_valid = 0;
    else if (!adv) begin
      if (wb_load_i && wb_rd_i != 0 && wb_rd_i == m_instr[19:15]) m_rs1d = wb_data_i;
      if (wb_load_i && wb_rd_i != 0 && wb_rd_i == m_instr[24:20]) m_rs2d = wb_data_i;
    end else if (haz) begin
      m_valid = 0;
      if (HAS_CNT && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_valid = if_valid_i;
      m_instr = if_instr_i;
      m_pc    = if_pc_i;
      m_rs1d  = f_read(if_instr_i[19:15]);
      m_rs2d  = f_read(if_instr_i[24:20]);
      m_imm   = f_imm(if_instr_i);
      m_br    = f_br(if_instr_i, m_rs1d, m_rs2d);
    end
    if (wb_load_i && wb_rd_i != 0) m_regs[wb_rd_i] = wb_data_i;
  endtask

  task automatic check_outputs();
    check_eq("ex_valid", ex_valid_o, m_valid);
    check_eq("hazard_cnt", hazard_cnt_o, m_cnt);
    if (m_valid) begin
      check_eq("ex_instr", ex_instr_o, m_instr);
      check_eq("ex_pc", ex_pc_o, m_pc);
      check_eq("ex_rs1_data", ex_rs1_data_o, m_rs1d);
      check_eq("ex_rs2_data", ex_rs2_data_o, m_rs2d);
      check_eq("ex_imm", ex_imm_o, m_imm);
      check_eq("ex_br_en", ex_br_en_o, m_br);
      check_eq("ex_rs1", ex_rs1_o, m_instr[19:15]);
      check_eq("ex_rs2", ex_rs2_o, m_instr[24:20]);
      check_eq("ex_rd", ex_rd_o, m_instr[11:7]);
      check_eq("ex_ctrl_opcode", ex_ctrl_word_o.opcode, m_instr[6:0]);
    end
  endtask

  // Inputs are already driven (just after a negedge); check ready, advance one edge.
  task automatic step();
    #1;
    if (!rst) check_eq("id_ready", id_ready_o, flush_i || ((!m_valid || ex_ready_i) && !f_haz()));
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                       input logic wl, input logic [4:0] wrd, input logic [31:0] wd);
    if_valid_i = v; if_instr_i = ins; ex_ready_i = rdy; flush_i = fl;
    wb_load_i = wl; wb_rd_i = wrd; wb_data_i = wd;
    if_pc_i = pc_ctr; pc_ctr = pc_ctr + 4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = ops[$urandom_range(0, 8)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
  localparam logic [31:0] LW_X2     = 32'h0000_A103;
  localparam logic [31:0] ADD_X3    = 32'h0021_01B3;
  localparam logic [31:0] ADD_X5_X4 = 32'h0002_02B3;
  localparam logic [31:0] ADD_X6_X7 = 32'h0003_8333;
  localparam logic [31:0] ADD_X8_20 = 32'h000A_0433;
  localparam logic [31:0] BLT_X1_X2 = 32'h0020_C063;
  localparam logic [31:0] BLTU_X1X2 = 32'h0020_E063;

  initial begin
    logic [31:0] cnt_before;
    pc_ctr = 32'h100;
    m_valid = 0; m_instr = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_br = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    rst = 1;
    drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    step();
    step();
    rst = 0;
    #1;
    check_eq("reset_ready", id_ready_o, 1'b1);
    check_eq("reset_valid", ex_valid_o, 1'b0);
    check_eq("reset_fields", {ex_instr_o, ex_imm_o}, 64'd0);
    check_eq("reset_ctrl", 64'(ex_ctrl_word_o), 64'd0);
    check_eq("reset_cnt", hazard_cnt_o, 32'd0);

    // Basic capture and idle
    drive(1, ADDI_X1_5, 1, 0, 0, 5'd0, 32'h0); step();
    check_eq("addi_imm", ex_imm_o, 32'd5);
    drive(0, 32'h0, 1, 0, 0, 5'd0, 32'h0); step();
    check_eq("idle_valid", ex_valid_o, 1'b0);

    // Load-use bubble
    drive(1, LW_X2, 1, 0, 0, 5'd0, 32'h0); step();
    drive(1, ADD_X3, 1, 0, 0, 5'd0, 32'h0); #1;
    check_eq("loaduse_ready", id_ready_o, 1'b0);
    #0 step();
    check_eq("bubble_valid", ex_valid_o, 1'b0);
    drive(1, ADD_X3, 1, 0, 0, 5'd0, 32'h0); step();
    check_eq("add_after_bubble", ex_instr_o, ADD_X3);
    check_eq("cnt_one", hazard_cnt_o, HAS_CNT ? 32'd1 : 32'd0);

    // Same-cycle writeback forwarding
    drive(1, ADD_X5_X4, 1, 0, 1, 5'd4, 32'hDEAD_BEEF); step();
    check_eq("wt_rs1", ex_rs1_data_o, 32'hDEAD_BEEF);

    // Held operand refresh
    drive(1, ADD_X6_X7, 1, 0, 0, 5'd0, 32'h0); step();
    drive(1, ADDI_X1_5, 0, 0, 1, 5'd7, 32'h1234); step();
    check_eq("hold_refresh", ex_rs1_data_o, 32'h1234);
    check_eq("hold_instr", ex_instr_o, ADD_X6_X7);

    // Flush beats a pending hazard and does not count
    drive(1, LW_X2, 1, 0, 0, 5'd0, 32'h0); step();
    cnt_before = m_cnt;
    drive(1, ADD_X3, 1, 1, 0, 5'd0, 32'h0); step();
    check_eq("flush_valid", ex_valid_o, 1'b0);
    check_eq("flush_cnt", hazard_cnt_o, cnt_before);

    // Out-of-range register on the 16-entry instance
    drive(0, 32'h0, 1, 0, 1, 5'd20, 32'd7); step();
    drive(1, ADD_X8_20, 1, 0, 0, 5'd0, 32'h0); step();
    check_eq("nr16_x20", d16_rs1_data, 32'd0);
    check_eq("nr32_x20", ex_rs1_data_o, 32'd7);

    // Signed vs unsigned branch compare
    drive(0, 32'h0, 1, 0, 1, 5'd1, 32'hFFFF_FFFF); step();
    drive(0, 32'h0, 1, 0, 1, 5'd2, 32'd1); step();
    drive(1, BLT_X1_X2, 1, 0, 0, 5'd0, 32'h0); step();
    check_eq("blt_taken", ex_br_en_o, 1'b1);
    drive(1, BLTU_X1X2, 1, 0, 0, 5'd0, 32'h0); step();
    check_eq("bltu_not_taken", ex_br_en_o, 1'b0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4,
            ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            $urandom);
      step();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised decode stage with a built-in ID/EX pipeline register, valid/ready handshakes on both sides, load-use hazard bubbles, flush, a write-through register file, and per-format immediate selection. It sits between the fetch stage and the execute stage and replaces the purely combinational decode plus external ID/EX register. It also provides a saturating hazard-stall performance counter.

## Interface
- WIDTH, 32, datapath/PC width; immediates sign-extended to WIDTH; must be ≥32.
- NUM_REGS, 32, architectural registers; 16 or 32.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_valid_i  in  1  fetch presents an instruction.
- if_instr_i  in  32  instruction word.
- if_pc_i  in  WIDTH  instruction PC.
- id_ready_o  out  1  decode accepts this cycle.
- ex_ready_i  in  1  execute accepts the registered instruction.
- ex_valid_o  out  1  registered instruction valid.
- ex_ctrl_word_o  out  rv32i_control_word  control word from control_rom.
- ex_instr_o  out  32  registered instruction word.
- ex_pc_o  out  WIDTH  registered PC.
- ex_rs1_data_o, ex_rs2_data_o  out  WIDTH  operand values.
- ex_imm_o  out  WIDTH  format-selected immediate.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5  register indices.
- ex_br_en_o  out  1  branch compare result on decode operands.
- flush_i  in  1  discard registered and incoming instruction.
- wb_load_i  in  1  writeback enable.
- wb_rd_i  in  5  writeback index.
- wb_data_i  in  WIDTH  writeback data.
- hazard_cnt_o  out  32  load-use bubble count.

## Operation
- Advance condition: `adv = !ex_valid_o || ex_ready_i`.
- Hazard condition: `haz = ex_valid_o && ex opcode==LOAD && ex_rd_o!=0 && ((rs1_used && rs1==ex_rd_o) || (rs2_used && rs2==ex_rd_o))`.
  - rs1_used for all opcodes except LUI, AUIPC, JAL.
  - rs2_used for OP, STORE, BRANCH.
- id_ready_o = flush_i || (adv && !haz).
- Priority: rst > flush_i > hold (!adv) > bubble (haz) > capture.
  - flush_i: ex_valid_o←0 next cycle. The fetch instruction is consumed and dropped.
  - hold: all ex_* registers keep their values.
  - bubble: ex_valid_o←0; other ex_* fields don't-care.
  - capture: ex_valid_o←if_valid_i; all fields load from the decode of if_instr_i.
- Immediate select, sign-extended from instr[31]:
  - I for OP-IMM, LOAD, JALR.
  - S for STORE.
  - B for BRANCH.
  - U for LUI, AUIPC.
  - J for JAL.
  - 0 otherwise.
- ex_br_en_o = cmp(funct3, rs1_data, rs2_data) using BEQ/BNE/BLT/BGE/BLTU/BGEU semantics. It is 0 for non-branches.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Indices ≥ NUM_REGS read 0; writes to them are ignored.
  - Same-cycle read of a register being written (wb_load_i, wb_rd_i≠0) returns wb_data_i.
- Held-operand refresh: while held, if wb_load_i && wb_rd_i≠0 matches ex_rs1_o or ex_rs2_o, the matching ex_rsN_data_o←wb_data_i.
- hazard_cnt_o increments on each cycle a bubble is actually inserted (adv && haz && !flush_i) and saturates at 0xFFFFFFFF.

## Timing
- Reset: ex_valid_o=0, every ex_* output=0 (ctrl word all-zero), all registers=0, hazard_cnt_o=0, id_ready_o=1 in the cycle after reset.
- Latency 1: an instruction accepted at edge N appears on ex_* after edge N.
- A load-use dependency costs exactly one bubble cycle. The dependent instruction is accepted on the next cycle, because the load then leaves EX.
- A writeback at edge N is visible through the write-through path in cycle N, and is stored from N+1.
- A flush coincident with a hazard or a hold is still honoured; the counter does not increment.
- Reset mid-stream clears the register file and all in-flight state.

## Configuration
- DECODE_HAZARD_CNT_EN:
  - Defined: the counter is as above.
  - Undefined: no counter flops; hazard_cnt_o tied to 0; all other behaviour is identical.

## Structure
- rv32i_types package:
  - Add the imm_sel_t enum (I, S, B, U, J, NONE).
  - Add the LOAD-opcode constant reuse.
  - rv32i_control_word and rv32i_opcode remain there.
- Sub-module decode_regfile: parameters WIDTH and NUM_REGS, write-through read, x0 and out-of-range handling.
- control_rom and cmp are instantiated unchanged.

## Test plan
- After reset, issue ADDI x1,x0,5 then a cycle of idle → ex_valid_o=1 one cycle after accept, ex_imm_o=5, then ex_valid_o=0; hazard_cnt_o=0.
- LW x2,0(x1) followed by ADD x3,x2,x2, with ex_ready_i=1 → id_ready_o=0 for one cycle, one bubble, ADD captured next cycle, hazard_cnt_o=1 (0 without macro).
- Writeback wb_rd_i=4, data 0xDEADBEEF in the same cycle as decode of ADD x5,x4,x0 → ex_rs1_data_o=0xDEADBEEF.
- Hold ex_ready_i=0 with ADD x6,x7,x0 registered, then write x7=0x1234 → ex_rs1_data_o becomes 0x1234 while held; no new capture.
- flush_i with if_valid_i=1 and a pending hazard → ex_valid_o=0 next cycle, id_ready_o=1, counter unchanged.
- NUM_REGS=16: write x20=7, then read x20 → 0. BLT x1,x2 with x1=-1 and x2=1 → ex_br_en_o=1. BLTU with the same operands → 0.
